wb_arbiter_rr: RTL and testbench
================================

Name: wb_arbiter_rr

Overview:
- Parametrised N-master to 1-slave Wishbone B3 arbiter.
- Successor to the single-fixed-priority arbiters that feed wb_intercon.
- Adds registered round-robin fairness, direct grant handover without an idle bubble, a grant/status export, and an optional bus-hang watchdog.
- Sits between the per-core data/instruction buses (packed vectors) and one wb_intercon master port.

Parameters:
- dw, 32, data width.
- aw, 32, address width.
- NUM_MASTERS, 2, number of masters (1..16).
- TIMEOUT, 255, watchdog limit in cycles (only used with WB_ARB_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- wbm_adr_i  in  aw*NUM_MASTERS  master addresses, master k at [k*aw +: aw].
- wbm_dat_i  in  dw*NUM_MASTERS  master write data.
- wbm_sel_i  in  4*NUM_MASTERS  byte selects.
- wbm_we_i / wbm_cyc_i / wbm_stb_i  in  NUM_MASTERS  each.
- wbm_cti_i  in  3*NUM_MASTERS  cycle type.
- wbm_bte_i  in  2*NUM_MASTERS  burst type.
- wbm_dat_o  out  dw*NUM_MASTERS  read data, slave data broadcast to all slices.
- wbm_ack_o / wbm_err_o / wbm_rty_o  out  NUM_MASTERS  each.
- wbs_adr_o  out  aw.
- wbs_dat_o  out  dw.
- wbs_sel_o  out  4.
- wbs_we_o / wbs_cyc_o / wbs_stb_o  out  1 each.
- wbs_cti_o  out  3.
- wbs_bte_o  out  2.
- wbs_dat_i  in  dw.
- wbs_ack_i / wbs_err_i / wbs_rty_i  in  1 each.
- grant_o  out  NUM_MASTERS  one-hot current grant, 0 when idle.
- busy_o  out  1  high in BUSY.

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is synchronous and active-low.
- Reset values:
  - state=IDLE, grant=0.
  - last_grant=NUM_MASTERS-1, so master 0 wins first.
  - Watchdog counter=0.
  - All slave outputs 0; all wbm ack/err/rty 0.
- Reset mid-transfer: grant drops at that edge; no ack is forwarded after it.
- State IDLE:
  - If any wbm_cyc_i bit is set, pick the first requester searching from last_grant+1 upward, wrapping modulo NUM_MASTERS.
  - Register the pick into grant and last_grant; go to BUSY.
  - Latency: slave cyc/stb appear 1 cycle after the master's cyc.
- State BUSY:
  - Slave outputs are a combinational mux of the granted master's adr/dat/sel/we/cyc/stb/cti/bte.
  - wbs_ack_i/err_i/rty_i are routed only to the granted bit; non-granted ack/err/rty stay 0.
  - The grant is held for the whole cycle (cyc high), including incrementing bursts (cti=010) and the end-of-burst beat (cti=111). No preemption.
- Release: on an edge where the granted wbm_cyc_i=0:
  - Other requests pending: re-arbitrate from the current grant+1 and grant the winner at the same edge (stay BUSY).
  - No other requests: go to IDLE, grant=0.
- Simultaneous requests: strict rotation. With all N requesting continuously, the order is 0,1,..,N-1,0.
- A master that drops and re-raises cyc in the same release cycle is searched last.
- NUM_MASTERS=1: rotation degenerates; master 0 is regranted whenever its cyc is high.
- A slave response when no grant or no stb is ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - Counter width $clog2(TIMEOUT+1).
  - Increments each cycle that wbs_stb_o=1 and none of ack/err/rty is 1.
  - Clears on any response, on cycles with wbs_stb_o=0, and on reset.
  - When the counter equals TIMEOUT: for exactly one cycle assert wbm_err_o[grant]=1 and force wbs_cyc_o=wbs_stb_o=0, then clear the counter. The grant is kept until the master drops cyc.
- Without the macro: no counter logic; a hung slave stalls the bus indefinitely.

Test Plan:
- Reset: assert rst_ni=0 for 2 cycles with all wbm_cyc_i=1 -> all outputs 0, grant_o=0. First grant after release is master 0.
- Round-robin: N=4, all masters hold single reads, slave acks each after 1 cycle, each master drops cyc after its ack -> grant_o sequence 0001,0010,0100,1000,0001 with no IDLE cycle between grants.
- Burst hold: master 1 issues a 4-beat cti=010 burst ending with cti=111 while master 0 requests -> master 0 is not granted until master 1 drops cyc. Exactly 4 acks reach wbm_ack_o[1] and none reach [0].
- Isolation: master 2 granted, slave returns err -> only wbm_err_o[2]=1. wbm_dat_o slices for all masters equal wbs_dat_i.
- Timeout (macro on, TIMEOUT=8): slave never acks -> wbm_err_o[granted]=1 on the 9th stb cycle, with wbs_stb_o=0 that cycle. Macro off -> stb stays high for more than 100 cycles.
- Reset mid-burst: rst_ni=0 during beat 2 -> wbs_cyc_o=0 at the next edge. A later ack pulse is not forwarded.

Source files
------------

// File: rtl/wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter_rr
//  Purpose  : N-master to 1-slave Wishbone B3 arbiter with registered
//             round-robin fairness, direct grant handover on release,
//             grant/busy export and an optional bus-hang watchdog.
//  Options  : WB_ARB_TIMEOUT_EN - enables the watchdog that errors out a
//             transfer after TIMEOUT unanswered strobe cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_rr #(
   parameter int dw          = 32,
   parameter int aw          = 32,
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   // master side (packed, master k at slice k)
   input  logic [aw*NUM_MASTERS-1:0] wbm_adr_i,
   input  logic [dw*NUM_MASTERS-1:0] wbm_dat_i,
   input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]    wbm_we_i,
   input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
   input  logic [3*NUM_MASTERS-1:0]  wbm_cti_i,
   input  logic [2*NUM_MASTERS-1:0]  wbm_bte_i,
   output logic [dw*NUM_MASTERS-1:0] wbm_dat_o,
   output logic [NUM_MASTERS-1:0]    wbm_ack_o,
   output logic [NUM_MASTERS-1:0]    wbm_err_o,
   output logic [NUM_MASTERS-1:0]    wbm_rty_o,
   // slave side
   output logic [aw-1:0]             wbs_adr_o,
   output logic [dw-1:0]             wbs_dat_o,
   output logic [3:0]                wbs_sel_o,
   output logic                      wbs_we_o,
   output logic                      wbs_cyc_o,
   output logic                      wbs_stb_o,
   output logic [2:0]                wbs_cti_o,
   output logic [1:0]                wbs_bte_o,
   input  logic [dw-1:0]             wbs_dat_i,
   input  logic                      wbs_ack_i,
   input  logic                      wbs_err_i,
   input  logic                      wbs_rty_i,
   // status
   output logic [NUM_MASTERS-1:0]    grant_o,
   output logic                      busy_o
);

   localparam int c_idx_w = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int c_sum_w = c_idx_w + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                   r_state, w_state_next;
   logic [NUM_MASTERS-1:0]   r_grant, w_grant_next, w_pick_onehot;
   logic [c_idx_w-1:0]       r_last_grant, w_last_next, w_start, w_pick_idx;
   logic [c_sum_w-1:0]       w_cand;
   logic                     w_pick_found;
   logic                     w_granted_cyc;
   logic                     w_timeout;

   logic [aw-1:0]            w_adr;
   logic [dw-1:0]            w_dat;
   logic [3:0]               w_sel;
   logic                     w_we, w_cyc, w_stb;
   logic [2:0]               w_cti;
   logic [1:0]               w_bte;

   // Search starts one past the last grant so the previous owner is looked at last
   always_comb begin
      if (r_last_grant == c_idx_w'(NUM_MASTERS - 1)) begin
         w_start = '0;
      end else begin
         w_start = r_last_grant + c_idx_w'(1);
      end
   end

   // Rotating first-requester search, wrapping modulo NUM_MASTERS
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_idx   = '0;
      w_cand       = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_cand = {1'b0, w_start} + c_sum_w'(i);
         if (w_cand >= c_sum_w'(NUM_MASTERS)) begin
            w_cand = w_cand - c_sum_w'(NUM_MASTERS);
         end
         if (!w_pick_found && wbm_cyc_i[w_cand[c_idx_w-1:0]]) begin
            w_pick_found = 1'b1;
            w_pick_idx   = w_cand[c_idx_w-1:0];
         end
      end
   end

   // One-hot form of the arbitration winner
   always_comb begin
      w_pick_onehot = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         w_pick_onehot[k] = w_pick_found && (w_pick_idx == c_idx_w'(k));
      end
   end

   assign w_granted_cyc = |(r_grant & wbm_cyc_i);

   // Next-state logic: grant from IDLE, hand over directly on release in BUSY
   always_comb begin
      w_state_next = r_state;
      w_grant_next = r_grant;
      w_last_next  = r_last_grant;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_found) begin
               w_state_next = ST_BUSY;
               w_grant_next = w_pick_onehot;
               w_last_next  = w_pick_idx;
            end
         end
         ST_BUSY: begin
            if (!w_granted_cyc) begin
               if (w_pick_found) begin
                  w_grant_next = w_pick_onehot;
                  w_last_next  = w_pick_idx;
               end else begin
                  w_state_next = ST_IDLE;
                  w_grant_next = '0;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_grant_next = '0;
         end
      endcase
   end

   // State, grant and rotation pointer registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= c_idx_w'(NUM_MASTERS - 1);
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_last_grant <= w_last_next;
      end
   end

   // Request mux: all-zero when nothing is granted
   always_comb begin
      w_adr = '0;
      w_dat = '0;
      w_sel = '0;
      w_we  = 1'b0;
      w_cyc = 1'b0;
      w_stb = 1'b0;
      w_cti = '0;
      w_bte = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (r_grant[k]) begin
            w_adr = wbm_adr_i[k*aw +: aw];
            w_dat = wbm_dat_i[k*dw +: dw];
            w_sel = wbm_sel_i[k*4 +: 4];
            w_we  = wbm_we_i[k];
            w_cyc = wbm_cyc_i[k];
            w_stb = wbm_stb_i[k];
            w_cti = wbm_cti_i[k*3 +: 3];
            w_bte = wbm_bte_i[k*2 +: 2];
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int c_wdog_w = $clog2(TIMEOUT + 1);

   logic [c_wdog_w-1:0] r_wdog;

   assign w_timeout = (|r_grant) && (r_wdog == c_wdog_w'(TIMEOUT));

   // Count unanswered strobe cycles; any response, idle strobe or expiry clears
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_wdog <= '0;
      end else if (w_timeout || !wbs_stb_o || wbs_ack_i || wbs_err_i || wbs_rty_i) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= r_wdog + c_wdog_w'(1);
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // On expiry the slave sees the cycle withdrawn while the master gets err
   assign wbs_adr_o = w_adr;
   assign wbs_dat_o = w_dat;
   assign wbs_sel_o = w_sel;
   assign wbs_we_o  = w_we;
   assign wbs_cyc_o = w_cyc & ~w_timeout;
   assign wbs_stb_o = w_stb & w_cyc & ~w_timeout;
   assign wbs_cti_o = w_cti;
   assign wbs_bte_o = w_bte;

   // Responses only count while the granted master is strobing
   assign wbm_ack_o = r_grant & {NUM_MASTERS{wbs_ack_i & wbs_stb_o}};
   assign wbm_err_o = r_grant & {NUM_MASTERS{(wbs_err_i & wbs_stb_o) | w_timeout}};
   assign wbm_rty_o = r_grant & {NUM_MASTERS{wbs_rty_i & wbs_stb_o}};
   assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

   assign grant_o = r_grant;
   assign busy_o  = (r_state == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter_rr
//  Purpose  : Self-checking bench for wb_arbiter_rr (4 masters, TIMEOUT=8)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_rr;

   localparam int NM = 4;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW*NM-1:0] m_adr;
   logic [DW*NM-1:0] m_dat;
   logic [4*NM-1:0]  m_sel;
   logic [NM-1:0]    m_we, m_cyc, m_stb;
   logic [3*NM-1:0]  m_cti;
   logic [2*NM-1:0]  m_bte;
   logic [DW*NM-1:0] m_dat_o;
   logic [NM-1:0]    m_ack, m_err, m_rty;
   logic [AW-1:0]    s_adr;
   logic [DW-1:0]    s_dat_o, s_dat;
   logic [3:0]       s_sel;
   logic             s_we, s_cyc, s_stb;
   logic [2:0]       s_cti;
   logic [1:0]       s_bte;
   logic             s_ack, s_err, s_rty;
   logic [NM-1:0]    grant;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0]  exp_grant_q[$];
   logic [34:0] exp_beat_q[$];
   logic [4:0]  exp_vec_q[$];
   int          exp_cnt_q[$];

   wb_arbiter_rr #(
      .dw(DW), .aw(AW), .NUM_MASTERS(NM), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel),
      .wbm_we_i(m_we), .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
      .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
      .wbm_dat_o(m_dat_o), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
      .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
      .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
      .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
      .grant_o(grant), .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   task automatic set_master(input int k, input logic cyc, input logic stb,
                             input logic [31:0] adr, input logic [2:0] cti);
      m_cyc[k] = cyc;
      m_stb[k] = stb;
      m_adr[k*AW +: AW] = adr;
      m_cti[k*3 +: 3] = cti;
   endtask

   task automatic clear_bus();
      m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0;
      m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
      s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
   endtask

   task automatic settle_idle();
      clear_bus();
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < NM; k++) set_master(k, 1'b1, 1'b1, 32'h1000_0000 + 32'(k*16), 3'b000);
      s_ack = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL reset_cyc_stb: got %b%b want 00", s_cyc, s_stb); end
      n_checks++; if (s_adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", s_adr); end
      n_checks++; if (m_ack !== 4'b0000 || m_err !== 4'b0000) begin n_fail++; $display("FAIL reset_resp: got ack %b err %b want 0", m_ack, m_err); end
      exp_grant_q.push_back(4'b0001);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp = exp_grant_q.pop_front();
      n_checks++; if (grant !== exp) begin n_fail++; $display("FAIL first_grant: got %b want %b", grant, exp); end
      n_checks++; if (s_adr !== 32'h1000_0000 || s_cyc !== 1'b1) begin n_fail++; $display("FAIL first_mux: got adr %h cyc %b want 10000000 1", s_adr, s_cyc); end
      n_checks++; if (m_ack !== 4'b0001) begin n_fail++; $display("FAIL first_ack_route: got %b want 0001", m_ack); end
      clear_bus();
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL release_idle: got busy %b grant %b want 0 0000", busy, grant); end
   endtask

   task automatic test_round_robin();
      logic [3:0] seen, dropped, acked, exp;
      logic       stb_prev, started;
      int         gaps, cnt;
      @(negedge clk);
      rst_n = 1'b0;
      clear_bus();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NM; k++) set_master(k, 1'b1, 1'b1, 32'h2000_0000 + 32'(k*256), 3'b000);
      exp_grant_q.push_back(4'b0001);
      exp_grant_q.push_back(4'b0010);
      exp_grant_q.push_back(4'b0100);
      exp_grant_q.push_back(4'b1000);
      exp_grant_q.push_back(4'b0001);
      seen = '0; dropped = '0; stb_prev = 1'b0; started = 1'b0; gaps = 0; cnt = 0;
      while (exp_grant_q.size() > 0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (grant !== seen) begin
            if (grant !== 4'b0000) begin
               exp = exp_grant_q.pop_front();
               n_checks++;
               if (grant !== exp) begin n_fail++; $display("FAIL rr_grant: got %b want %b", grant, exp); end
               started = 1'b1;
            end
            seen = grant;
         end
         if (started && busy !== 1'b1) gaps++;
         for (int k = 0; k < NM; k++) begin
            if (dropped[k]) begin m_cyc[k] = 1'b1; m_stb[k] = 1'b1; end
         end
         dropped = '0;
         acked = m_ack;
         if (s_ack) begin
            s_ack = 1'b0;
            stb_prev = 1'b0;
            for (int k = 0; k < NM; k++) begin
               if (acked[k]) begin m_cyc[k] = 1'b0; m_stb[k] = 1'b0; dropped[k] = 1'b1; end
            end
         end else begin
            if (s_stb && stb_prev) s_ack = 1'b1;
            stb_prev = s_stb;
         end
      end
      n_checks++; if (exp_grant_q.size() != 0) begin n_fail++; $display("FAIL rr_timeout: got %0d grants pending want 0", exp_grant_q.size()); exp_grant_q.delete(); end
      n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL rr_no_idle: got %0d idle cycles want 0", gaps); end
      @(negedge clk);
      settle_idle();
   endtask

   task automatic test_burst_hold();
      logic [3:0]  seen, exp;
      logic [34:0] beat_exp;
      logic [31:0] base;
      int          b, ack0, ack1, preempt, cnt;
      base = 32'h3000_0000;
      @(negedge clk);
      set_master(1, 1'b1, 1'b1, base, 3'b010);
      exp_grant_q.push_back(4'b0010);
      exp_grant_q.push_back(4'b0001);
      for (int i = 0; i < 4; i++) exp_beat_q.push_back({(i == 3) ? 3'b111 : 3'b010, base + 32'(4*i)});
      seen = '0; b = 0; ack0 = 0; ack1 = 0; preempt = 0; cnt = 0;
      while (exp_grant_q.size() > 0 && cnt < 60) begin
         @(negedge clk);
         cnt++;
         if (grant !== seen) begin
            if (grant !== 4'b0000) begin
               exp = exp_grant_q.pop_front();
               n_checks++;
               if (grant !== exp) begin n_fail++; $display("FAIL burst_grant: got %b want %b", grant, exp); end
               if (grant === 4'b0010) set_master(0, 1'b1, 1'b1, 32'h3100_0000, 3'b000);
            end
            seen = grant;
         end
         if (b < 4 && grant[0] === 1'b1) preempt++;
         ack0 += int'(m_ack[0]);
         ack1 += int'(m_ack[1]);
         if (s_ack) begin
            if (exp_beat_q.size() > 0) begin
               beat_exp = exp_beat_q.pop_front();
               n_checks++;
               if ({s_cti, s_adr} !== beat_exp) begin n_fail++; $display("FAIL burst_beat: got %h want %h", {s_cti, s_adr}, beat_exp); end
            end
            b++;
            if (b < 4) set_master(1, 1'b1, 1'b1, base + 32'(4*b), (b == 3) ? 3'b111 : 3'b010);
            else set_master(1, 1'b0, 1'b0, 32'h0, 3'b000);
         end
         s_ack = (b < 4) && s_stb;
      end
      n_checks++; if (exp_grant_q.size() != 0 || exp_beat_q.size() != 0) begin n_fail++; $display("FAIL burst_timeout: got %0d/%0d pending want 0/0", exp_grant_q.size(), exp_beat_q.size()); exp_grant_q.delete(); exp_beat_q.delete(); end
      n_checks++; if (ack1 != 4) begin n_fail++; $display("FAIL burst_ack1: got %0d want 4", ack1); end
      n_checks++; if (ack0 != 0) begin n_fail++; $display("FAIL burst_ack0: got %0d want 0", ack0); end
      n_checks++; if (preempt != 0) begin n_fail++; $display("FAIL burst_preempt: got %0d want 0", preempt); end
      @(negedge clk);
      settle_idle();
   endtask

   task automatic test_isolation();
      logic [3:0] exp;
      logic [4:0] vexp;
      int         cnt;
      @(negedge clk);
      set_master(0, 1'b1, 1'b1, 32'h4000_0000, 3'b000);
      set_master(2, 1'b1, 1'b1, 32'h4000_0040, 3'b000);
      m_dat[2*DW +: DW] = 32'hDEAD_BEEF;
      m_sel[2*4 +: 4] = 4'hC;
      m_we[2] = 1'b1;
      exp_grant_q.push_back(4'b0100);
      cnt = 0;
      while (grant === 4'b0000 && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      exp = exp_grant_q.pop_front();
      n_checks++; if (grant !== exp) begin n_fail++; $display("FAIL iso_grant: got %b want %b", grant, exp); end
      n_checks++; if (s_adr !== 32'h4000_0040 || s_dat_o !== 32'hDEAD_BEEF || s_sel !== 4'hC || s_we !== 1'b1)
         begin n_fail++; $display("FAIL iso_mux: got %h %h %h %b want 40000040 deadbeef c 1", s_adr, s_dat_o, s_sel, s_we); end
      exp_vec_q.push_back({1'b0, 4'b0100});
      s_dat = 32'hA5A5_5A5A;
      s_err = 1'b1;
      #1;
      vexp = exp_vec_q.pop_front();
      n_checks++; if (m_err !== vexp[3:0]) begin n_fail++; $display("FAIL iso_err: got %b want %b", m_err, vexp[3:0]); end
      n_checks++; if (m_ack !== 4'b0000 || m_rty !== 4'b0000) begin n_fail++; $display("FAIL iso_err_only: got ack %b rty %b want 0", m_ack, m_rty); end
      n_checks++; if (m_dat_o !== {4{32'hA5A5_5A5A}}) begin n_fail++; $display("FAIL iso_dat_bcast: got %h", m_dat_o); end
      exp_vec_q.push_back({1'b0, 4'b0100});
      s_err = 1'b0;
      s_rty = 1'b1;
      s_dat = 32'h0123_4567;
      #1;
      vexp = exp_vec_q.pop_front();
      n_checks++; if (m_rty !== vexp[3:0] || m_err !== 4'b0000) begin n_fail++; $display("FAIL iso_rty: got rty %b err %b want %b 0000", m_rty, m_err, vexp[3:0]); end
      n_checks++; if (m_dat_o !== {4{32'h0123_4567}}) begin n_fail++; $display("FAIL iso_dat_bcast2: got %h", m_dat_o); end
      s_rty = 1'b0;
      m_stb[2] = 1'b0;
      s_ack = 1'b1;
      #1;
      n_checks++; if (m_ack !== 4'b0000) begin n_fail++; $display("FAIL iso_no_stb_ack: got %b want 0000", m_ack); end
      @(negedge clk);
      settle_idle();
   endtask

   task automatic test_timeout();
      logic [4:0] vexp;
      int         cnt;
      @(negedge clk);
      set_master(3, 1'b1, 1'b1, 32'h5000_0000, 3'b000);
      cnt = 0;
      while (grant !== 4'b1000 && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL to_grant: got %b want 1000", grant); end
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 1; i <= 10; i++) exp_vec_q.push_back((i == 9) ? {1'b0, 4'b1000} : {1'b1, 4'b0000});
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) @(negedge clk);
         vexp = exp_vec_q.pop_front();
         n_checks++;
         if ({s_stb, m_err} !== vexp) begin n_fail++; $display("FAIL to_cycle%0d: got stb/err %b want %b", i, {s_stb, m_err}, vexp); end
      end
      n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL to_grant_kept: got %b want 1000", grant); end
`else
      exp_cnt_q.push_back(110);
      vexp = '0;
      cnt = 0;
      for (int i = 1; i <= 110; i++) begin
         if (i > 1) @(negedge clk);
         if (s_stb === 1'b1) cnt++;
         vexp[3:0] = vexp[3:0] | m_err;
      end
      n_checks++; if (cnt != exp_cnt_q.pop_front()) begin n_fail++; $display("FAIL hang_stb: got %0d stb cycles want 110", cnt); end
      n_checks++; if (vexp[3:0] !== 4'b0000) begin n_fail++; $display("FAIL hang_err: got %b want 0000", vexp[3:0]); end
`endif
      @(negedge clk);
      settle_idle();
   endtask

   task automatic test_reset_mid_burst();
      int b, cnt, n_ack;
      @(negedge clk);
      set_master(1, 1'b1, 1'b1, 32'h6000_0000, 3'b010);
      exp_cnt_q.push_back(2);
      b = 0; cnt = 0; n_ack = 0;
      while (b < 2 && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (s_ack) begin
            n_ack += int'(m_ack[1]);
            b++;
            set_master(1, 1'b1, 1'b1, 32'h6000_0000 + 32'(4*b), 3'b010);
         end
         s_ack = (b < 2) && s_stb;
      end
      n_checks++; if (n_ack != exp_cnt_q.pop_front()) begin n_fail++; $display("FAIL mid_pre_acks: got %0d want 2", n_ack); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_fail++; $display("FAIL mid_cyc_drop: got %b%b want 00", s_cyc, s_stb); end
      n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mid_grant_drop: got %b want 0000", grant); end
      s_ack = 1'b1;
      #1;
      n_checks++; if (m_ack !== 4'b0000) begin n_fail++; $display("FAIL mid_ack_in_reset: got %b want 0000", m_ack); end
      @(negedge clk);
      m_cyc = '0;
      m_stb = '0;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (m_ack !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_late_ack: got ack %b busy %b want 0000 0", m_ack, busy); end
      settle_idle();
   endtask

   initial begin
      clear_bus();
      test_reset();
      test_round_robin();
      test_burst_hold();
      test_isolation();
      test_timeout();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
